// File: rtl/alu_pkg.sv
// Package alu_pkg
// Purpose: shared constants and types for the sequential ALU slice.
//   - OP_* : 4-bit opcode values (same encoding as the old combinational ALU)
//   - state_t : handshake FSM states (IDLE, BUSY, DONE)
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NAND = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_GT   = 4'd12;
    localparam logic [3:0] OP_LT   = 4'd13;
    localparam logic [3:0] OP_EQ   = 4'd14;
    localparam logic [3:0] OP_INC  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_param_if.sv
// Interface alu_seq_param_if
// Purpose: operand/result handshake bundle of the sequential ALU.
// Signals:
//   in_valid, in_ready, op[3:0], a, b         : operand channel
//   out_valid, out_ready, res, res_hi          : result channel
//   carry, zero, div0                          : status flags of the held result
// Modports:
//   master : front end / producer side (drives operands, consumes results)
//   slave  : the ALU itself
interface alu_seq_param_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             carry;
    logic             zero;
    logic             div0;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, res_hi, carry, zero, div0
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, res_hi, carry, zero, div0
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Module alu_iter_muldiv
// Purpose: WIDTH-cycle iterative multiplier (shift-add) and divider (restoring).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin an operation (one-cycle pulse)
//   is_div     : 1 = divide, 0 = multiply (sampled with start)
//   a, b       : operands (multiplicand/multiplier or dividend/divisor)
//   done       : high during the cycle whose rising edge performs the last step
//   hi, lo     : MUL -> {hi,lo} = a*b ; DIV -> hi = remainder, lo = quotient
// hi/lo hold their final values after the last step until the next start.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic             div_mode;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    // Multiply: hi accumulates, lo shifts the multiplier out / product in.
    // Divide: {hi,lo} shifts left, lo collects quotient bits, hi is the partial remainder.
    // The remainder stays below the divisor, so the true difference fits WIDTH bits.
    always_comb begin
        add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_shift = {hi, lo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, operand});
        rem_diff  = rem_shift[WIDTH-1:0] - operand;
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            busy     <= 1'b0;
            div_mode <= 1'b0;
            operand  <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (start) begin
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
            div_mode <= is_div;
            operand  <= b;
            hi       <= '0;
            lo       <= a;
        end else if (busy) begin
            if (div_mode) begin
                hi <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], rem_ge};
            end else begin
                hi <= add_sum[WIDTH:1];
                lo <= {add_sum[0], lo[WIDTH-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Module alu_seq_param
// Purpose: clocked, parametrised 16-op ALU with valid/ready handshake,
//          iterative full-width MUL/DIV and status flags.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_seq_param_if.slave
//           in_valid/in_ready/op/a/b     operand handshake
//           out_valid/out_ready          result handshake
//           res, res_hi, carry, zero, div0  held result and flags
// Single-cycle ops are captured into output registers at the accept edge.
// MUL/DIV results are read straight from the iterative unit, which holds
// them until the next start (only possible after the result is popped).
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_param_if.slave bus
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             needs_iter;
    logic             start_iter;
    logic             load_fast;
    logic             is_div_in;

    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   add_wide;
    logic [WIDTH:0]   inc_wide;
    logic [2*WIDTH-1:0] shl_wide;
    logic [2*WIDTH-1:0] shr_wide;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] fast_hi;
    logic             fast_carry;
    logic             fast_div0;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             carry_q;
    logic             zero_q;
    logic             div0_q;
    logic             is_div_q;
    logic             from_iter;

    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign shamt      = bus.b[SW-1:0];
    assign is_div_in  = (bus.op == OP_DIV);
    assign needs_iter = (bus.op == OP_MUL) || (is_div_in && (bus.b != '0));

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_iter),
        .is_div (is_div_in),
        .a      (bus.a),
        .b      (bus.b),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // BUSY leaves on the same edge that performs the last iteration step,
    // which gives WIDTH+1 cycles for MUL/DIV and 1 cycle for everything else.
    always_comb begin
        next_state = state;
        start_iter = 1'b0;
        load_fast  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (needs_iter) begin
                        start_iter = 1'b1;
                        next_state = ST_BUSY;
                    end else begin
                        load_fast  = 1'b1;
                        next_state = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shifts run in a double-width field so the shifted-out bits land in the
    // other half and can be OR-reduced into carry; s==0 leaves that half empty.
    always_comb begin
        add_wide   = {1'b0, bus.a} + {1'b0, bus.b};
        inc_wide   = {1'b0, bus.a} + {{WIDTH{1'b0}}, 1'b1};
        shl_wide   = {{WIDTH{1'b0}}, bus.a} << shamt;
        shr_wide   = {bus.a, {WIDTH{1'b0}}} >> shamt;
        fast_res   = '0;
        fast_hi    = '0;
        fast_carry = 1'b0;
        fast_div0  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                fast_res   = add_wide[WIDTH-1:0];
                fast_carry = add_wide[WIDTH];
            end
            OP_SUB: begin
                fast_res   = bus.a - bus.b;
                fast_carry = (bus.a >= bus.b);
            end
            OP_DIV: begin
                fast_res  = '1;
                fast_hi   = bus.a;
                fast_div0 = 1'b1;
            end
            OP_AND:  fast_res = bus.a & bus.b;
            OP_OR:   fast_res = bus.a | bus.b;
            OP_XOR:  fast_res = bus.a ^ bus.b;
            OP_NAND: fast_res = ~(bus.a & bus.b);
            OP_NOR:  fast_res = ~(bus.a | bus.b);
            OP_XNOR: fast_res = ~(bus.a ^ bus.b);
            OP_SHL: begin
                fast_res   = shl_wide[WIDTH-1:0];
                fast_carry = |shl_wide[2*WIDTH-1:WIDTH];
            end
            OP_SHR: begin
                fast_res   = shr_wide[2*WIDTH-1:WIDTH];
                fast_carry = |shr_wide[WIDTH-1:0];
            end
            OP_GT:  fast_res = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_LT:  fast_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_EQ:  fast_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_INC: begin
                fast_res   = inc_wide[WIDTH-1:0];
                fast_carry = inc_wide[WIDTH];
            end
            default: begin
                fast_res = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            hi_q      <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            from_iter <= 1'b0;
        end else if (load_fast) begin
            res_q     <= fast_res;
            hi_q      <= fast_hi;
            carry_q   <= fast_carry;
            zero_q    <= (fast_res == '0) && (fast_hi == '0);
            div0_q    <= fast_div0;
            from_iter <= 1'b0;
        end else if (start_iter) begin
            is_div_q  <= is_div_in;
            from_iter <= 1'b1;
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.res       = from_iter ? iter_lo : res_q;
    assign bus.res_hi    = from_iter ? iter_hi : hi_q;
    assign bus.carry     = from_iter ? (!is_div_q && (iter_hi != '0)) : carry_q;
    assign bus.zero      = from_iter ? ((iter_lo == '0) && (iter_hi == '0)) : zero_q;
    assign bus.div0      = from_iter ? 1'b0 : div0_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Testbench tb_alu_seq_param
// Purpose: directed, table-driven check of alu_seq_param at WIDTH=8 and
//          WIDTH=4 (two instances, selected by sel4), plus hand-written
//          backpressure and mid-operation reset sequences.
module tb_alu_seq_param;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       w4;
        logic [7:0] exp_res;
        logic [7:0] exp_hi;
        logic       exp_carry;
        logic       exp_zero;
        logic       exp_div0;
        int         exp_lat;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       sel4;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;

    logic       in_ready_s;
    logic       out_valid_s;
    logic [7:0] res_s;
    logic [7:0] hi_s;
    logic       carry_s;
    logic       zero_s;
    logic       div0_s;

    int checks;
    int errors;
    vec_t vecs[$];

    alu_seq_param_if #(.WIDTH(8)) bus8 ();
    alu_seq_param_if #(.WIDTH(4)) bus4 ();

    assign bus8.in_valid  = in_valid && !sel4;
    assign bus8.out_ready = out_ready && !sel4;
    assign bus8.op        = op;
    assign bus8.a         = a;
    assign bus8.b         = b;
    assign bus4.in_valid  = in_valid && sel4;
    assign bus4.out_ready = out_ready && sel4;
    assign bus4.op        = op;
    assign bus4.a         = a[3:0];
    assign bus4.b         = b[3:0];

    alu_seq_param #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_seq_param #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always_comb begin
        if (sel4) begin
            in_ready_s  = bus4.in_ready;
            out_valid_s = bus4.out_valid;
            res_s       = {4'b0, bus4.res};
            hi_s        = {4'b0, bus4.res_hi};
            carry_s     = bus4.carry;
            zero_s      = bus4.zero;
            div0_s      = bus4.div0;
        end else begin
            in_ready_s  = bus8.in_ready;
            out_valid_s = bus8.out_valid;
            res_s       = bus8.res;
            hi_s        = bus8.res_hi;
            carry_s     = bus8.carry;
            zero_s      = bus8.zero;
            div0_s      = bus8.div0;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Presents one operation, waits for the accept edge, then counts cycles
    // until out_valid; lat=1 means out_valid is high right after the accept edge.
    task automatic applyStimulus(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                 output int lat, output logic saw_ready);
        int n;
        op       = o;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready_s && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        lat       = 1;
        saw_ready = 1'b0;
        while (!out_valid_s && lat < 60) begin
            if (in_ready_s) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic popResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compare({tag, ".popped_valid"}, {31'b0, out_valid_s}, 0);
    endtask

    task automatic checkOutput(input string tag, input vec_t v, input int lat, input logic saw_ready);
        compare({tag, ".lat"},   lat, v.exp_lat);
        compare({tag, ".valid"}, {31'b0, out_valid_s}, 1);
        compare({tag, ".res"},   {24'b0, res_s}, {24'b0, v.exp_res});
        compare({tag, ".hi"},    {24'b0, hi_s}, {24'b0, v.exp_hi});
        compare({tag, ".carry"}, {31'b0, carry_s}, {31'b0, v.exp_carry});
        compare({tag, ".zero"},  {31'b0, zero_s}, {31'b0, v.exp_zero});
        compare({tag, ".div0"},  {31'b0, div0_s}, {31'b0, v.exp_div0});
        if (v.exp_lat > 1) begin
            compare({tag, ".ready_while_busy"}, {31'b0, saw_ready}, 0);
        end
    endtask

    // SUB 3-5 held under backpressure for 10 cycles while a new ADD 1+1 is
    // offered; the ADD must only be taken the cycle after the pop.
    task automatic backpressure(input logic w4, input logic [7:0] exp_sub);
        int   lat;
        logic rdy;
        string tag;
        tag  = w4 ? "bp4" : "bp8";
        sel4 = w4;
        applyStimulus(OP_SUB, 8'd3, 8'd5, lat, rdy);
        compare({tag, ".lat"}, lat, 1);
        op       = OP_ADD;
        a        = 8'd1;
        b        = 8'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            compare($sformatf("%s.hold%0d.res", tag, i), {24'b0, res_s}, {24'b0, exp_sub});
            compare($sformatf("%s.hold%0d.carry", tag, i), {31'b0, carry_s}, 0);
            compare($sformatf("%s.hold%0d.valid", tag, i), {31'b0, out_valid_s}, 1);
            compare($sformatf("%s.hold%0d.ready", tag, i), {31'b0, in_ready_s}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        compare({tag, ".after_pop_valid"}, {31'b0, out_valid_s}, 0);
        compare({tag, ".after_pop_ready"}, {31'b0, in_ready_s}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        compare({tag, ".next_valid"}, {31'b0, out_valid_s}, 1);
        compare({tag, ".next_res"}, {24'b0, res_s}, 32'd2);
        popResult(tag);
    endtask

    initial begin
        int   lat;
        logic rdy;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        sel4      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = OP_ADD;
        a         = '0;
        b         = '0;

        //          op       a       b      w4    res     hi    c     z     d0   lat
        vecs.push_back('{OP_ADD,  8'd200, 8'd100, 1'b0, 8'd44,  8'd0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_MUL,  8'd255, 8'd255, 1'b0, 8'd1,   8'd254, 1'b1, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_DIV,  8'd100, 8'd7,   1'b0, 8'd14,  8'd2, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_DIV,  8'd5,   8'd0,   1'b0, 8'd255, 8'd5, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_SHL,  8'hC3,  8'd2,   1'b0, 8'h0C,  8'd0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SHR,  8'h01,  8'd1,   1'b0, 8'd0,   8'd0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_SHL,  8'h81,  8'h08,  1'b0, 8'h81,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SUB,  8'd10,  8'd3,   1'b0, 8'd7,   8'd0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_AND,  8'hF0,  8'h3C,  1'b0, 8'h30,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_OR,   8'h12,  8'h21,  1'b0, 8'h33,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_XOR,  8'hAA,  8'hAA,  1'b0, 8'h00,  8'd0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_NAND, 8'hF0,  8'h0F,  1'b0, 8'hFF,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_NOR,  8'h0F,  8'hF0,  1'b0, 8'h00,  8'd0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_XNOR, 8'h0F,  8'h0F,  1'b0, 8'hFF,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_INC,  8'd255, 8'd0,   1'b0, 8'd0,   8'd0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_GT,   8'd5,   8'd3,   1'b0, 8'd1,   8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_LT,   8'd5,   8'd3,   1'b0, 8'd0,   8'd0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_EQ,   8'd7,   8'd7,   1'b0, 8'd1,   8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_MUL,  8'd12,  8'd10,  1'b0, 8'd120, 8'd0, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_MUL,  8'd0,   8'd77,  1'b0, 8'd0,   8'd0, 1'b0, 1'b1, 1'b0, 9});
        vecs.push_back('{OP_DIV,  8'd7,   8'd9,   1'b0, 8'd0,   8'd7, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_ADD,  8'd12,  8'd6,   1'b1, 8'd2,   8'd0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_MUL,  8'd15,  8'd15,  1'b1, 8'd1,   8'd14, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_DIV,  8'd13,  8'd4,   1'b1, 8'd3,   8'd1, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_DIV,  8'd9,   8'd0,   1'b1, 8'd15,  8'd9, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_SHL,  8'h0B,  8'd2,   1'b1, 8'h0C,  8'd0, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SHR,  8'h01,  8'd1,   1'b1, 8'd0,   8'd0, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_SHL,  8'h05,  8'h04,  1'b1, 8'h05,  8'd0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SUB,  8'd3,   8'd5,   1'b1, 8'd14,  8'd0, 1'b0, 1'b0, 1'b0, 1});

        #12;
        compare("reset.valid", {31'b0, out_valid_s}, 0);
        compare("reset.ready", {31'b0, in_ready_s}, 1);
        compare("reset.res",   {24'b0, res_s}, 0);
        compare("reset.hi",    {24'b0, hi_s}, 0);
        compare("reset.flags", {29'b0, carry_s, zero_s, div0_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            sel4 = vecs[i].w4;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i], lat, rdy);
            popResult($sformatf("vec%0d", i));
        end

        backpressure(1'b0, 8'd254);
        backpressure(1'b1, 8'd14);

        // Reset during cycle 4 of a MUL: outputs clear at once and no result follows.
        sel4     = 1'b0;
        op       = OP_MUL;
        a        = 8'd255;
        b        = 8'd255;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare("midrst.valid", {31'b0, out_valid_s}, 0);
        compare("midrst.ready", {31'b0, in_ready_s}, 1);
        compare("midrst.res",   {24'b0, res_s}, 0);
        compare("midrst.hi",    {24'b0, hi_s}, 0);
        compare("midrst.flags", {29'b0, carry_s, zero_s, div0_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        compare("midrst.no_result", {31'b0, out_valid_s}, 0);
        applyStimulus(OP_ADD, 8'd1, 8'd1, lat, rdy);
        compare("midrst.add_lat", lat, 1);
        compare("midrst.add_res", {24'b0, res_s}, 32'd2);
        compare("midrst.add_carry", {31'b0, carry_s}, 0);
        popResult("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
